// File: rtl/game_master_fsm_multi_if.sv
// Bundle of signals between the game master and its sprites, collision
// detectors, fire key and end-of-game timer.
interface game_master_fsm_multi_if #(
    parameter int N_TARGETS   = 2,
    parameter int N_SHOTS     = 3,
    parameter int SCORE_WIDTH = 8
);
    localparam int SHOT_W = $clog2(N_SHOTS + 1);

    logic                   key;
    logic [N_TARGETS-1:0]   sprite_target_write_xy;
    logic [N_TARGETS-1:0]   sprite_target_write_dxy;
    logic [N_TARGETS-1:0]   sprite_target_enable_update;
    logic                   sprite_torpedo_write_xy;
    logic                   sprite_torpedo_write_dxy;
    logic                   sprite_torpedo_enable_update;
    logic [N_TARGETS-1:0]   sprite_target_within_screen;
    logic                   sprite_torpedo_within_screen;
    logic [N_TARGETS-1:0]   collision;
    logic                   end_of_game_timer_start;
    logic                   end_of_game_timer_running;
    logic                   game_won;
    logic [SCORE_WIDTH-1:0] score;
    logic [SHOT_W-1:0]      shots_left;

    modport master (
        input  key, sprite_target_within_screen, sprite_torpedo_within_screen,
               collision, end_of_game_timer_running,
        output sprite_target_write_xy, sprite_target_write_dxy,
               sprite_target_enable_update, sprite_torpedo_write_xy,
               sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
               end_of_game_timer_start, game_won, score, shots_left
    );

    modport slave (
        output key, sprite_target_within_screen, sprite_torpedo_within_screen,
               collision, end_of_game_timer_running,
        input  sprite_target_write_xy, sprite_target_write_dxy,
               sprite_target_enable_update, sprite_torpedo_write_xy,
               sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
               end_of_game_timer_start, game_won, score, shots_left
    );
endinterface

// File: rtl/game_master_fsm_multi.sv
// Game master for N targets and one reusable torpedo: round sequencing,
// shot budget, per-target alive mask and a saturating score.
module game_master_fsm_multi #(
    parameter int N_TARGETS   = 2,
    parameter int N_SHOTS     = 3,
    parameter int SCORE_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    game_master_fsm_multi_if.master bus
);
    localparam int SHOT_W = $clog2(N_SHOTS + 1);

    typedef enum logic [3:0] {
        S_START = 4'b0001,
        S_AIM   = 4'b0010,
        S_SHOOT = 4'b0100,
        S_END   = 4'b1000
    } state_t;

    state_t                 state;
    logic [N_TARGETS-1:0]   alive;
    logic                   key_prev;
    logic [N_TARGETS-1:0]   target_write_xy;
    logic [N_TARGETS-1:0]   target_write_dxy;
    logic [N_TARGETS-1:0]   target_enable;
    logic                   torpedo_write_xy;
    logic                   torpedo_write_dxy;
    logic                   torpedo_enable;
    logic                   timer_start;
    logic                   game_won;
    logic [SCORE_WIDTH-1:0] score;
    logic [SHOT_W-1:0]      shots_left;

    logic                     key_rise;
    logic                     target_off;
    logic [N_TARGETS-1:0]     hit;
    logic [N_TARGETS-1:0]     alive_after;
    logic [3:0]               hit_cnt;
    logic [SCORE_WIDTH+3:0]   score_wide;
    logic [SCORE_WIDTH-1:0]   score_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        hit_cnt     = 4'd0;
        key_rise    = bus.key & ~key_prev;
        target_off  = |(alive & ~bus.sprite_target_within_screen);
        hit         = bus.collision & alive;
        alive_after = alive & ~hit;
        for (int i = 0; i < N_TARGETS; i++) begin
            hit_cnt = hit_cnt + 4'(hit[i]);
        end
        score_wide = {4'b0, score} + {{SCORE_WIDTH{1'b0}}, hit_cnt};
        // Any carry out of the score field means we passed all-ones: clamp.
        score_next = (score_wide[SCORE_WIDTH+3:SCORE_WIDTH] != 4'b0)
                   ? {SCORE_WIDTH{1'b1}} : score_wide[SCORE_WIDTH-1:0];
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_START;
            alive             <= '0;
            key_prev          <= 1'b0;
            target_write_xy   <= '0;
            target_write_dxy  <= '0;
            target_enable     <= '0;
            torpedo_write_xy  <= 1'b0;
            torpedo_write_dxy <= 1'b0;
            torpedo_enable    <= 1'b0;
            timer_start       <= 1'b0;
            game_won          <= 1'b0;
            score             <= '0;
            shots_left        <= '0;
        end else begin
            key_prev          <= bus.key;
            target_write_xy   <= '0;
            target_write_dxy  <= '0;
            target_enable     <= '0;
            torpedo_write_xy  <= 1'b0;
            torpedo_write_dxy <= 1'b0;
            torpedo_enable    <= 1'b0;
            timer_start       <= 1'b0;

            case (state)
                S_START: begin
                    target_write_xy  <= '1;
                    target_write_dxy <= '1;
                    torpedo_write_xy <= 1'b1;
                    alive            <= '1;
                    shots_left       <= SHOT_W'(N_SHOTS);
                    game_won         <= 1'b0;
                    state            <= S_AIM;
                end
                S_AIM: begin
                    target_enable <= alive;
                    if (target_off) begin
                        timer_start <= 1'b1;
                        game_won    <= 1'b0;
                        state       <= S_END;
                    end else if (key_rise && shots_left != '0) begin
                        shots_left <= shots_left - SHOT_W'(1);
                        state      <= S_SHOOT;
                    end
                end
                S_SHOOT: begin
                    torpedo_write_dxy <= 1'b1;
                    torpedo_enable    <= 1'b1;
                    target_enable     <= alive;
                    alive             <= alive_after;
                    score             <= score_next;
                    if (alive_after == '0) begin
                        game_won    <= 1'b1;
                        timer_start <= 1'b1;
                        state       <= S_END;
                    end else if (target_off) begin
                        game_won    <= 1'b0;
                        timer_start <= 1'b1;
                        state       <= S_END;
                    end else if (hit != '0 || !bus.sprite_torpedo_within_screen) begin
                        // Torpedo is spent: reload it, then aim again or close the round.
                        torpedo_write_xy <= 1'b1;
                        if (shots_left != '0) begin
                            state <= S_AIM;
                        end else begin
                            game_won    <= 1'b0;
                            timer_start <= 1'b1;
                            state       <= S_END;
                        end
                    end
                end
                S_END: begin
                    if (!bus.end_of_game_timer_running) state <= S_START;
                end
                default: state <= S_START;
            endcase
        end
    end

    assign bus.sprite_target_write_xy       = target_write_xy;
    assign bus.sprite_target_write_dxy      = target_write_dxy;
    assign bus.sprite_target_enable_update  = target_enable;
    assign bus.sprite_torpedo_write_xy      = torpedo_write_xy;
    assign bus.sprite_torpedo_write_dxy     = torpedo_write_dxy;
    assign bus.sprite_torpedo_enable_update = torpedo_enable;
    assign bus.end_of_game_timer_start      = timer_start;
    assign bus.game_won                     = game_won;
    assign bus.score                        = score;
    assign bus.shots_left                   = shots_left;
endmodule
